// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [DW-1:0] IRdata,
    output logic          IValid,
    output logic          IStall,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWdata,
    input  logic [DW/8-1:0] DBe,
    output logic [DW-1:0] DRdata,
    output logic          DValid,
    output logic          DStall,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    output logic [DW/8-1:0] MemBe,
    input  logic          MemReady,
    input  logic [DW-1:0] MemRdata
);

    typedef enum logic [2:0] {IDLE, IACC, DACC, IDONE, DDONE} state_t;

    state_t state, state_nxt;
    logic   last_d;
    logic   grant_i, grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // On a tie, last_d=1 means data was served last, so fetch wins.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (IReq && (!DReq || last_d)) begin
                    grant_i   = 1'b1;
                    state_nxt = IACC;
                end else if (DReq) begin
                    grant_d   = 1'b1;
                    state_nxt = DACC;
                end
            end
            IACC:    if (MemReady) state_nxt = IDONE;
            DACC:    if (MemReady) state_nxt = DDONE;
            IDONE:   state_nxt = IDLE;
            DDONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d   <= 1'b1;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWdata <= '0;
            MemBe    <= '0;
            IRdata   <= '0;
            DRdata   <= '0;
        end else begin
            if (grant_i) begin
                MemWe    <= 1'b0;
                MemAddr  <= IAddr;
                MemWdata <= '0;
                MemBe    <= '1;
            end
            if (grant_d) begin
                MemWe    <= DWe;
                MemAddr  <= DAddr;
                MemWdata <= DWdata;
                MemBe    <= DBe;
            end
            if (state == IACC && MemReady) begin
                IRdata <= MemRdata;
                last_d <= 1'b0;
            end
            if (state == DACC && MemReady) begin
                last_d <= 1'b1;
                if (!MemWe) DRdata <= MemRdata;
            end
        end
    end

    // Decoded from state so an async reset drops them immediately.
    assign MemReq = (state == IACC) || (state == DACC);
    assign IValid = (state == IDONE);
    assign DValid = (state == DDONE);
    assign IStall = IReq & ~IValid;
    assign DStall = DReq & ~DValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRdata;
    logic        IValid, IStall;
    logic        DReq, DWe;
    logic [31:0] DAddr, DWdata;
    logic [3:0]  DBe;
    logic [31:0] DRdata;
    logic        DValid, DStall;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWdata;
    logic [3:0]  MemBe;
    logic        MemReady;
    logic [31:0] MemRdata;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IValid(IValid), .IStall(IStall),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DBe(DBe),
        .DRdata(DRdata), .DValid(DValid), .DStall(DStall),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemBe(MemBe), .MemReady(MemReady), .MemRdata(MemRdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; IReq = 0; IAddr = 0; DReq = 0; DWe = 0; DAddr = 0;
        DWdata = 0; DBe = 0; MemReady = 0; MemRdata = 0;
        #1;
        checks++; if (MemReq !== 1'b0)    begin errors++; $display("FAIL reset_memreq got=%h exp=0", MemReq); end
        checks++; if (MemWe !== 1'b0)     begin errors++; $display("FAIL reset_memwe got=%h exp=0", MemWe); end
        checks++; if (MemAddr !== 32'h0)  begin errors++; $display("FAIL reset_memaddr got=%h exp=0", MemAddr); end
        checks++; if (MemWdata !== 32'h0) begin errors++; $display("FAIL reset_memwdata got=%h exp=0", MemWdata); end
        checks++; if (MemBe !== 4'h0)     begin errors++; $display("FAIL reset_membe got=%h exp=0", MemBe); end
        checks++; if ({IValid, DValid} !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", {IValid, DValid}); end
        checks++; if (IRdata !== 32'h0)   begin errors++; $display("FAIL reset_irdata got=%h exp=0", IRdata); end
        checks++; if (DRdata !== 32'h0)   begin errors++; $display("FAIL reset_drdata got=%h exp=0", DRdata); end
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_fetch;
        IAddr = 32'h100; IReq = 1; MemReady = 1; MemRdata = 32'h00500093;
        #1;
        checks++; if (IStall !== 1'b1) begin errors++; $display("FAIL fetch_istall_c0 got=%b exp=1", IStall); end
        tick;
        checks++; if (MemReq !== 1'b1)     begin errors++; $display("FAIL fetch_memreq_c1 got=%b exp=1", MemReq); end
        checks++; if (MemAddr !== 32'h100) begin errors++; $display("FAIL fetch_memaddr got=%h exp=100", MemAddr); end
        checks++; if (MemWe !== 1'b0)      begin errors++; $display("FAIL fetch_memwe got=%b exp=0", MemWe); end
        checks++; if (MemBe !== 4'hF)      begin errors++; $display("FAIL fetch_membe got=%h exp=f", MemBe); end
        checks++; if (MemWdata !== 32'h0)  begin errors++; $display("FAIL fetch_memwdata got=%h exp=0", MemWdata); end
        checks++; if ({IStall, IValid} !== 2'b10) begin errors++; $display("FAIL fetch_c1_stall_valid got=%b exp=10", {IStall, IValid}); end
        tick;
        checks++; if (IValid !== 1'b1)          begin errors++; $display("FAIL fetch_ivalid_c2 got=%b exp=1", IValid); end
        checks++; if (IRdata !== 32'h00500093)  begin errors++; $display("FAIL fetch_irdata got=%h exp=00500093", IRdata); end
        checks++; if (IStall !== 1'b0)          begin errors++; $display("FAIL fetch_istall_c2 got=%b exp=0", IStall); end
        IReq = 0;
        tick;
        checks++; if ({IValid, MemReq} !== 2'b00) begin errors++; $display("FAIL fetch_c3_idle got=%b exp=00", {IValid, MemReq}); end
    endtask

    task automatic test_store_wait;
        DWe = 1; DAddr = 32'h2000; DWdata = 32'hDEADBEEF; DBe = 4'h3; DReq = 1;
        MemReady = 0; MemRdata = 32'h12345678;
        for (int c = 1; c <= 4; c++) begin
            tick;
            checks++;
            if ({MemReq, MemWe, MemAddr, MemWdata, MemBe, DValid} !== {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'h3, 1'b0}) begin
                errors++;
                $display("FAIL store_fields_c%0d got req=%b we=%b addr=%h wd=%h be=%h dv=%b exp 1 1 2000 deadbeef 3 0",
                         c, MemReq, MemWe, MemAddr, MemWdata, MemBe, DValid);
            end
            if (c == 4) MemReady = 1;
        end
        tick;
        checks++; if (DValid !== 1'b1)   begin errors++; $display("FAIL store_dvalid_c5 got=%b exp=1", DValid); end
        checks++; if (DRdata !== 32'h0)  begin errors++; $display("FAIL store_drdata got=%h exp=0", DRdata); end
        checks++; if (DStall !== 1'b0)   begin errors++; $display("FAIL store_dstall_c5 got=%b exp=0", DStall); end
        DReq = 0; MemReady = 0;
        tick;
        checks++; if (DValid !== 1'b0)   begin errors++; $display("FAIL store_dvalid_c6 got=%b exp=0", DValid); end
    endtask

    task automatic test_load_churn;
        DWe = 0; DAddr = 32'h40; DBe = 4'hF; DReq = 1; MemReady = 0; MemRdata = 32'hCAFEF00D;
        tick;
        checks++; if ({MemReq, MemAddr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL churn_c1 got req=%b addr=%h exp 1 40", MemReq, MemAddr); end
        DAddr = 32'h80; DWe = 1;
        tick;
        checks++; if ({MemAddr, MemWe} !== {32'h40, 1'b0}) begin errors++; $display("FAIL churn_c2 got addr=%h we=%b exp 40 0", MemAddr, MemWe); end
        MemReady = 1;
        tick;
        checks++; if (DValid !== 1'b1)          begin errors++; $display("FAIL load_dvalid got=%b exp=1", DValid); end
        checks++; if (DRdata !== 32'hCAFEF00D)  begin errors++; $display("FAIL load_drdata got=%h exp=cafef00d", DRdata); end
        DReq = 0; DWe = 0; MemReady = 0;
        tick;
    endtask

    task automatic test_flush;
        IAddr = 32'h300; IReq = 1; MemReady = 0; MemRdata = 32'h0BADF00D;
        tick;
        checks++; if ({MemReq, MemAddr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL flush_c1 got req=%b addr=%h exp 1 300", MemReq, MemAddr); end
        IReq = 0;
        #1;
        checks++; if (IStall !== 1'b0) begin errors++; $display("FAIL flush_istall got=%b exp=0", IStall); end
        tick;
        checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL flush_no_abort got=%b exp=1", MemReq); end
        MemReady = 1;
        tick;
        checks++; if (IValid !== 1'b1) begin errors++; $display("FAIL flush_ivalid got=%b exp=1", IValid); end
        checks++; if (IRdata !== 32'h0BADF00D) begin errors++; $display("FAIL flush_irdata got=%h exp=0badf00d", IRdata); end
        MemReady = 0;
        tick;
        checks++; if ({IValid, MemReq} !== 2'b00) begin errors++; $display("FAIL flush_c4 got=%b exp=00", {IValid, MemReq}); end
        tick;
        checks++; if ({IValid, MemReq} !== 2'b00) begin errors++; $display("FAIL flush_no_regrant got=%b exp=00", {IValid, MemReq}); end
    endtask

    task automatic test_contention;
        logic exp_iv, exp_dv, exp_req;
        logic [31:0] exp_addr;
        reset = 1;
        tick;
        reset = 0;
        IAddr = 32'h10; DAddr = 32'h20; DWe = 0; DBe = 4'hF;
        IReq = 1; DReq = 1; MemReady = 1; MemRdata = 32'h55;
        for (int c = 1; c <= 12; c++) begin
            tick;
            exp_iv   = (c == 2) || (c == 8);
            exp_dv   = (c == 5) || (c == 11);
            exp_req  = (c % 3) == 1;
            exp_addr = (c == 1 || c == 7) ? 32'h10 : 32'h20;
            checks++;
            if ({IValid, DValid, MemReq} !== {exp_iv, exp_dv, exp_req}) begin
                errors++;
                $display("FAIL contention_c%0d got iv/dv/req=%b%b%b exp=%b%b%b", c, IValid, DValid, MemReq, exp_iv, exp_dv, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (MemAddr !== exp_addr) begin
                    errors++;
                    $display("FAIL contention_grant_c%0d got addr=%h exp=%h", c, MemAddr, exp_addr);
                end
            end
        end
        IReq = 0; DReq = 0; MemReady = 0;
        tick; tick;
    endtask

    task automatic test_reset_mid_access;
        DReq = 1; DWe = 0; DAddr = 32'h44; DBe = 4'hF; MemReady = 0;
        tick;
        checks++; if (MemReq !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", MemReq); end
        #2 reset = 1;
        #1;
        checks++; if ({MemReq, DValid} !== 2'b00) begin errors++; $display("FAIL rstmid_async got req/dv=%b exp=00", {MemReq, DValid}); end
        checks++; if (MemAddr !== 32'h0) begin errors++; $display("FAIL rstmid_memaddr got=%h exp=0", MemAddr); end
        #1 reset = 0;
        #1;
        checks++; if ({MemReq, DValid} !== 2'b00) begin errors++; $display("FAIL rstmid_release got=%b exp=00", {MemReq, DValid}); end
        tick;
        checks++; if ({MemReq, MemAddr, DValid} !== {1'b1, 32'h44, 1'b0}) begin
            errors++; $display("FAIL rstmid_regrant got req=%b addr=%h dv=%b exp 1 44 0", MemReq, MemAddr, DValid);
        end
        MemReady = 1;
        tick;
        checks++; if (DValid !== 1'b1) begin errors++; $display("FAIL rstmid_dvalid got=%b exp=1", DValid); end
        DReq = 0; MemReady = 0;
        tick;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_store_wait;
        test_load_churn;
        test_flush;
        test_contention;
        test_reset_mid_access;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
